// File: rtl/sr_pulse_gen.sv
// Set/reset request conditioner: two-flop synchronisers, per-channel debounce,
// and registered reset-dominant edge pulses that never assert set and reset together.
module sr_pulse_gen #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_raw,
    input  logic r_raw,
    output logic s_pulse,
    output logic r_pulse,
    output logic s_level,
    output logic r_level,
    output logic conflict
);

    localparam int CH_S = 0;
    localparam int CH_R = 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       level_q;
    logic [1:0]       level_d;
    logic [1:0]       rise;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             s_pulse_q, s_pulse_d;
    logic             r_pulse_q, r_pulse_d;
    logic             conflict_q, conflict_d;

    assign raw = {r_raw, s_raw};

    // Any sample agreeing with the current level restarts the count.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            level_d[c] = level_q[c];
            cnt_d[c]   = '0;
            if (sync2_q[c] != level_q[c]) begin
                if (cnt_q[c] == CNT_TC) begin
                    level_d[c] = sync2_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = level_d & ~level_q;

    // Reset wins a simultaneous accept so the latch never sees S=R=1.
    always_comb begin
        s_pulse_d  = rise[CH_S] & ~rise[CH_R];
        r_pulse_d  = rise[CH_R];
        conflict_d = rise[CH_S] & rise[CH_R];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= '0;
            end
            s_pulse_q  <= 1'b0;
            r_pulse_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            s_pulse_q  <= s_pulse_d;
            r_pulse_q  <= r_pulse_d;
            conflict_q <= conflict_d;
        end
    end

    assign s_pulse  = s_pulse_q;
    assign r_pulse  = r_pulse_q;
    assign s_level  = level_q[CH_S];
    assign r_level  = level_q[CH_R];
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: a sample-history reference model predicts
// every output each cycle, plus directed latency and pulse-count checks.
module tb_sr_pulse_gen;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_raw = 1'b0;
    logic r_raw = 1'b0;
    logic s_pulse, r_pulse, s_level, r_level, conflict;

    sr_pulse_gen #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_raw    (s_raw),
        .r_raw    (r_raw),
        .s_pulse  (s_pulse),
        .r_pulse  (r_pulse),
        .s_level  (s_level),
        .r_level  (r_level),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: level flips once DB samples in a row since the last
    // flip all disagree with it.
    bit m_s1[2], m_s2[2], m_lv[2];
    bit h0[$];
    bit h1[$];
    logic [4:0] exp_q[$];

    function automatic bit all_differ(input bit h[$], input bit lvl);
        if (h.size() != DB) return 1'b0;
        foreach (h[i]) if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lv[c] = 0;
        end
        h0.delete();
        h1.delete();
        exp_q.push_back(5'b0);
    endtask

    task automatic model_step(input bit s, input bit r);
        bit raw[2];
        bit rise[2];
        bit d;
        bit flip;
        raw[0] = s;
        raw[1] = r;
        for (int c = 0; c < 2; c++) begin
            d = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
            rise[c] = 0;
            if (c == 0) begin
                h0.push_back(d);
                if (h0.size() > DB) void'(h0.pop_front());
                flip = all_differ(h0, m_lv[0]);
                if (flip) h0.delete();
            end else begin
                h1.push_back(d);
                if (h1.size() > DB) void'(h1.pop_front());
                flip = all_differ(h1, m_lv[1]);
                if (flip) h1.delete();
            end
            if (flip) begin
                m_lv[c] = !m_lv[c];
                rise[c] = m_lv[c];
            end
        end
        exp_q.push_back({rise[0] & !rise[1], rise[1], m_lv[0], m_lv[1], rise[0] & rise[1]});
    endtask

    int cyc = 0;
    int ns = 0, nr = 0, nc = 0;
    int s_at = -1, r_at = -1, c_at = -1, s_fall = -1;
    logic prev_s_level = 1'b0;

    task automatic cycle(input bit s, input bit r, input bit rst);
        logic [4:0] got;
        logic [4:0] exp;
        @(negedge clk);
        s_raw = s;
        r_raw = r;
        rst_n = rst;
        if (!rst) model_reset();
        else model_step(s, r);
        @(posedge clk);
        #1;
        got = {s_pulse, r_pulse, s_level, r_level, conflict};
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            chk("outs", {27'd0, got}, {27'd0, exp});
        end
        chk("s_and_r", {31'd0, s_pulse & r_pulse}, 32'd0);
        if (s_pulse) begin ns++; s_at = cyc; end
        if (r_pulse) begin nr++; r_at = cyc; end
        if (conflict) begin nc++; c_at = cyc; end
        if (prev_s_level && !s_level) s_fall = cyc;
        prev_s_level = s_level;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1);
    endtask

    int t0, ns0, nr0, nc0;
    bit rs, rr;

    initial begin
        // Reset held with both inputs high, then release into a simultaneous accept.
        for (int i = 0; i < 4; i++) cycle(1, 1, 0);
        chk("rst_quiet", ns + nr + nc, 0);
        t0 = cyc; ns0 = ns; nr0 = nr; nc0 = nc;
        for (int i = 0; i < 10; i++) cycle(1, 1, 1);
        chk("rst_rel_r_lat", r_at - t0, 5);
        chk("rst_rel_c_lat", c_at - t0, 5);
        chk("rst_rel_npulse_r", nr - nr0, 1);
        chk("rst_rel_npulse_s", ns - ns0, 0);
        chk("rst_rel_nconf", nc - nc0, 1);

        // Asynchronous assertion clears outputs before the next edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {27'd0, s_pulse, r_pulse, s_level, r_level, conflict}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        idle(4);

        // Clean set held 20 cycles, then release.
        t0 = cyc; ns0 = ns; nr0 = nr; nc0 = nc;
        for (int i = 0; i < 20; i++) cycle(1, 0, 1);
        chk("set_lat", s_at - t0, 5);
        chk("set_npulse", ns - ns0, 1);
        chk("set_level", {31'd0, s_level}, 32'd1);
        t0 = cyc;
        idle(12);
        chk("rel_lat", s_fall - t0, 5);
        chk("rel_nopulse", (ns - ns0) + (nr - nr0) + (nc - nc0), 1);

        // Bounce shorter than the debounce window is rejected.
        ns0 = ns;
        cycle(1, 0, 1); cycle(1, 0, 1); cycle(1, 0, 1); cycle(0, 0, 1);
        cycle(1, 0, 1); cycle(1, 0, 1); cycle(1, 0, 1);
        idle(10);
        chk("bounce_npulse", ns - ns0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 1);
        idle(12);
        chk("bounce_hold_npulse", ns - ns0, 1);

        // Staggered: r rises one cycle after s.
        t0 = cyc; ns0 = ns; nr0 = nr; nc0 = nc;
        cycle(1, 0, 1);
        for (int i = 0; i < 12; i++) cycle(1, 1, 1);
        chk("stag_s_lat", s_at - t0, 5);
        chk("stag_r_lat", r_at - t0, 6);
        chk("stag_conf", nc - nc0, 0);
        chk("stag_npulse", (ns - ns0) + (nr - nr0), 2);
        idle(12);

        // Reset mid-count discards partial progress.
        ns0 = ns;
        for (int i = 0; i < 4; i++) cycle(1, 0, 1);
        cycle(1, 0, 0); cycle(1, 0, 0);
        t0 = cyc;
        for (int i = 0; i < 10; i++) cycle(1, 0, 1);
        chk("midrst_lat", s_at - t0, 5);
        chk("midrst_npulse", ns - ns0, 1);
        idle(12);

        // Random bouncing on both channels against the model.
        rs = 0; rr = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rs = !rs;
            if ($urandom_range(0, 5) == 0) rr = !rr;
            cycle(rs, rr, 1);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sr_pulse_gen.md
# sr_pulse_gen

Upstream conditioning stage for the SR latch. Takes two raw, asynchronous set/reset inputs from switches or push-buttons, synchronises and debounces each, and issues clean single-cycle set and reset pulses. The two pulses are never asserted together, so the downstream latch never sees its forbidden S=R=1 input. Debounced levels and a conflict flag are also exported for status and debug.

## Interface

Parameters:
- DB_CYCLES, 4, consecutive synchronised samples that must differ from the current debounced level before the level flips; legal range 1..2^CNT_W.
- CNT_W, 3, width of each debounce counter; must satisfy 2^CNT_W >= DB_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; its deassertion is synchronous to clk at system level.
- s_raw  input  1  raw set request; asynchronous, may bounce.
- r_raw  input  1  raw reset request; asynchronous, may bounce.
- s_pulse  output  1  registered one-cycle set pulse to the latch s input.
- r_pulse  output  1  registered one-cycle reset pulse to the latch r input.
- s_level  output  1  registered debounced level of s_raw.
- r_level  output  1  registered debounced level of r_raw.
- conflict  output  1  registered one-cycle flag: set and reset rising edges were accepted on the same clock.

## Operation

- Synchronisation: each raw input passes through a 2-flop synchroniser (sync1, then sync2). Only sync2 feeds the debouncer.
- Debounce, per channel, independently. Each channel has a counter cnt[CNT_W-1:0]. On every rising edge:
  - If sync2 == level: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: level <= sync2 and cnt <= 0.
  - Else: cnt <= cnt + 1.
- A single sample in which sync2 matches the level restarts the count. A glitch shorter than DB_CYCLES samples therefore never changes the level.
- Edge detect: rise_s = (next s_level == 1) && (s_level == 0). rise_r is formed the same way. Falling edges produce no pulse.
- Pulse arbitration is registered and computed every cycle. Reset dominates:
  - rise_r && rise_s: r_pulse <= 1, s_pulse <= 0, conflict <= 1.
  - rise_r only: r_pulse <= 1.
  - rise_s only: s_pulse <= 1.
  - All other cases: s_pulse, r_pulse and conflict <= 0.
- Invariant: s_pulse && r_pulse is never 1.
- Both debounced levels may be high at the same time. This is legal and produces no pulses beyond the initial edge pulses.
- A held input produces exactly one pulse, however long it is held.

## Timing

- Reset (rst_n = 0, asynchronous): sync flops, cnt, s_level, r_level, s_pulse, r_pulse and conflict all go to 0 immediately and stay at 0 while rst_n is low.
- Reset asserted mid-count discards the partial count. After release, debouncing restarts from level 0 with a fresh synchroniser fill.
- Latency: with raw stable high from before rising edge k (edge k samples it):
  - sync2 = 1 after edge k+1.
  - level and pulse are set at edge k+1+DB_CYCLES.
  - For DB_CYCLES = 4 this is edge k+5, i.e. the 6th sampling edge.
- s_pulse/r_pulse are high for exactly one clock, in the first cycle that the corresponding level reads 1.
- Release latency is the same (DB_CYCLES+2 edges) for the level falling. No pulse is generated on release.
- The minimum re-trigger period for a second pulse on one channel is 2*(DB_CYCLES) edges after sync2 toggles: one fall period plus one rise period.
- conflict is coincident with the r_pulse it accompanies.

## Test plan

- Reset: hold rst_n = 0 with s_raw = r_raw = 1. Required: all outputs 0 throughout. Release rst_n with inputs held. Required: after 6 edges, r_pulse = 1, conflict = 1, s_pulse = 0, for one cycle only.
- Clean set (DB_CYCLES = 4): raise s_raw before edge k and hold it for 20 cycles. Required: s_level = 1 and s_pulse = 1 at edge k+5, s_pulse = 0 at edge k+6 and later, with no other pulses.
- Bounce rejection: s_raw high for 3 cycles, low for 1, high for 3, then low. Required: s_level stays 0 and no pulse appears. Then hold s_raw high for 4+ cycles. Required: exactly one s_pulse.
- Staggered inputs: r_raw rises 1 cycle after s_raw. Required: s_pulse one cycle before r_pulse, never both high in the same cycle, and conflict = 0.
- Mid-count reset: s_raw high, assert rst_n low at count 2, release with s_raw still high. Required: no pulse until 6 edges after release, then one s_pulse.
- Release: drop s_raw after s_level = 1. Required: s_level falls 6 edges later, with s_pulse, r_pulse and conflict remaining 0.
